i2s_rx_10xe_deserializer: RTL and testbench
===========================================

// Module: i2s_rx_10xe_deserializer
// PURPOSE
//  Downstream stage of the I2S transmitter. Consumes the serial outputs sclk/lrclk/sdata_0 and recovers
//  left/right PCM samples. It oversamples the serial lines in the aud_mclk domain and buffers the words
//  in a small FIFO. Words leave on a stream-style valid/ready port. Serves as loopback checker and
//  audio-capture front end.
// PARAMETERS
//  DATA_WIDTH   24  sample bits captured per channel, MSB first
//  SLOT_WIDTH   32  sclk periods per channel slot; bits after DATA_WIDTH are ignored
//  FIFO_DEPTH   4   output FIFO entries, power of 2, >=2
//  SYNC_STAGES  2   synchronizer flops on sclk_in/lrclk_in/sdata_in, >=2
// PORTS
//  aud_mclk     in   1                  master audio clock; must be >= 4x sclk frequency
//  aud_mrst     in   1                  async active-high reset
//  enable       in   1                  receiver enable; level-sensitive
//  sclk_in      in   1                  serial bit clock, from transmitter sclk_out
//  lrclk_in     in   1                  word select, 0 = left, 1 = right
//  sdata_in     in   1                  serial data, from transmitter sdata_0_out
//  m_tdata      out  DATA_WIDTH         sample at FIFO head
//  m_tid        out  1                  channel of head sample, 0 = left, 1 = right
//  m_tvalid     out  1                  FIFO non-empty
//  m_tready     in   1                  consumer accept
//  fifo_count   out  $clog2(FIFO_DEPTH)+1  occupied entries
//  overflow     out  1                  sticky: a word was dropped because the FIFO was full
//  clr_overflow in   1                  one-cycle clear of overflow
//  frame_err    out  1                  one-cycle pulse: lrclk toggled before DATA_WIDTH bits were captured
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state IDLE, sync flops 0.
//  Sync/edge: inputs pass through SYNC_STAGES flops. An sclk rise (srise) is a synced sclk 0->1 transition.
//   srise lags the pin by SYNC_STAGES+1 mclk. lrclk and sdata are sampled only on srise.
//  Channel boundary: at srise, sampled lrclk != previous sampled lrclk.
//   I2S 1-bit delay: the boundary srise samples the previous word's LSB and discards it.
//   The next DATA_WIDTH srises capture MSB..LSB.
//  FSM (enum in package):
//   IDLE   - enable=0 -> WAIT_LR when enable=1
//   WAIT_LR- wait for first boundary (discard partial first slot) -> SHIFT, bitcnt=0
//   SHIFT  - each srise shifts sdata into shreg, bitcnt++; at bitcnt==DATA_WIDTH-1 srise -> push word, -> SKIP
//   SKIP   - ignore padding srises; boundary -> SHIFT, bitcnt=0, channel=new lrclk
//   boundary seen in SHIFT -> frame_err pulse, partial word dropped, restart SHIFT for new channel
//   enable=0 in any state -> IDLE next cycle; partial word dropped; FIFO contents and overflow retained
//  Push: word and channel are written 1 mclk after the final-bit srise.
//   m_tvalid rises the cycle after a push into an empty FIFO.
//  Pop: m_tvalid && m_tready; head advances next cycle; FIFO is first-word fall-through registered.
//  Full + push, no pop: word dropped, overflow<=1. Full + push + pop same cycle: push accepted, no overflow.
//  Empty + pop attempt: no effect.
//  overflow: set wins over clr_overflow in the same cycle.
//  fifo_count: +1 push, -1 pop, unchanged on simultaneous push and pop.
// STRUCTURE
//  i2s_tx_10xe_defines gains: typedef enum rx_state_e {IDLE,WAIT_LR,SHIFT,SKIP}; CH_LEFT=0, CH_RIGHT=1.
//  Sub-module i2s_rx_10xe_sample_fifo: (DATA_WIDTH+1)-bit wide, FIFO_DEPTH deep, wrapping pointers
//   with an extra MSB for full/empty.
//  Top holds the synchronizers, edge detect, FSM, shift register and bit counter.
// TESTING
//  1. DATA_WIDTH=24, SLOT=32, sclk=mclk/8.
//     Send L=24'hA5_5A_C3, R=24'h0F_F0_1E -> two words out, tid 0 then 1, exact data.
//  2. Enable mid-slot -> first partial slot dropped; first word out is from the first full slot after a boundary.
//  3. m_tready=0, send 6 words with FIFO_DEPTH=4 -> fifo_count=4, overflow=1, first 4 words intact.
//     Pulse clr_overflow -> overflow=0.
//  4. Full FIFO, m_tready=1 on the push cycle -> no overflow; count stays 4.
//  5. Toggle lrclk after 10 bits -> frame_err one cycle; no word pushed; next full slot decodes correctly.
//  6. Assert aud_mrst mid-word -> all outputs 0 immediately.
//     Drop enable mid-word -> IDLE; FIFO contents still readable.

Source files
------------

// File: rtl/i2s_rx_10xe_deserializer_pkg.sv
// Shared types and constants for the I2S receive path: FSM states and channel codes.
package i2s_rx_10xe_deserializer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LR = 2'd1,
        SHIFT   = 2'd2,
        SKIP    = 2'd3
    } rx_state_e;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_10xe_sample_fifo.sv
// First-word fall-through sample FIFO; head entry is driven straight from the storage flops.
module i2s_rx_10xe_sample_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic                     aud_mclk,
    input  logic                     aud_mrst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop_req,
    input  logic                     clr_overflow,
    output logic [WIDTH-1:0]         head_data,
    output logic                     not_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             wr;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = !empty && pop_req;
    assign wr    = push && (!full || pop);

    always_ff @(posedge aud_mclk or posedge aud_mrst) begin
        if (aud_mrst) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr) begin
                mem[wptr[AW-1:0]] <= push_data;
                wptr              <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    assign count     = wptr - rptr;
    assign head_data = mem[rptr[AW-1:0]];
    assign not_empty = !empty;

endmodule

// File: rtl/i2s_rx_10xe_deserializer.sv
// I2S receiver: oversamples sclk/lrclk/sdata in the aud_mclk domain, deframes
// left/right words and queues them for a valid/ready consumer.
module i2s_rx_10xe_deserializer
    import i2s_rx_10xe_deserializer_pkg::*;
#(
    parameter int DATA_WIDTH  = 24,
    parameter int SLOT_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          aud_mclk,
    input  logic                          aud_mrst,
    input  logic                          enable,
    input  logic                          sclk_in,
    input  logic                          lrclk_in,
    input  logic                          sdata_in,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tid,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic                          frame_err
);

    localparam int BW = $clog2(SLOT_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic                   sclk_s;
    logic                   lr_s;
    logic                   sd_s;
    logic                   sclk_prev;
    logic                   lr_prev;
    logic                   srise;
    logic                   boundary;

    rx_state_e              state;
    rx_state_e              state_next;
    logic                   cnt_clear;
    logic                   cnt_inc;
    logic                   shift_en;
    logic                   push_set;
    logic                   ferr_set;
    logic                   ch_load;

    logic [DATA_WIDTH-1:0]  shreg;
    logic [BW-1:0]          bitcnt;
    logic                   ch;
    logic                   push_q;
    logic [DATA_WIDTH:0]    head;

    assign sclk_s   = sclk_sync[SYNC_STAGES-1];
    assign lr_s     = lr_sync[SYNC_STAGES-1];
    assign sd_s     = sd_sync[SYNC_STAGES-1];
    assign srise    = sclk_s && !sclk_prev;
    assign boundary = srise && (lr_s != lr_prev);

    // lr_prev tracks the line even while disabled so a fresh enable waits for a real boundary.
    always_ff @(posedge aud_mclk or posedge aud_mrst) begin
        if (aud_mrst) begin
            sclk_sync <= '0;
            lr_sync   <= '0;
            sd_sync   <= '0;
            sclk_prev <= 1'b0;
            lr_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], lrclk_in};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], sdata_in};
            sclk_prev <= sclk_s;
            if (srise) begin
                lr_prev <= lr_s;
            end
        end
    end

    always_ff @(posedge aud_mclk or posedge aud_mrst) begin
        if (aud_mrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The boundary srise carries the previous word's LSB, so it never shifts.
    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        shift_en   = 1'b0;
        push_set   = 1'b0;
        ferr_set   = 1'b0;
        ch_load    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = WAIT_LR;
                end
            end
            WAIT_LR, SKIP: begin
                if (boundary) begin
                    state_next = SHIFT;
                    cnt_clear  = 1'b1;
                    ch_load    = 1'b1;
                end
            end
            SHIFT: begin
                if (boundary) begin
                    ferr_set  = 1'b1;
                    cnt_clear = 1'b1;
                    ch_load   = 1'b1;
                end else if (srise) begin
                    shift_en = 1'b1;
                    if (bitcnt == LAST_BIT) begin
                        push_set   = 1'b1;
                        state_next = SKIP;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (!enable) begin
            state_next = IDLE;
            cnt_clear  = 1'b0;
            cnt_inc    = 1'b0;
            shift_en   = 1'b0;
            push_set   = 1'b0;
            ferr_set   = 1'b0;
            ch_load    = 1'b0;
        end
    end

    always_ff @(posedge aud_mclk or posedge aud_mrst) begin
        if (aud_mrst) begin
            shreg     <= '0;
            bitcnt    <= '0;
            ch        <= CH_LEFT;
            push_q    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            push_q    <= push_set;
            frame_err <= ferr_set;
            if (shift_en) begin
                shreg <= {shreg[DATA_WIDTH-2:0], sd_s};
            end
            if (cnt_clear) begin
                bitcnt <= '0;
            end else if (cnt_inc) begin
                bitcnt <= bitcnt + 1'b1;
            end
            if (ch_load) begin
                ch <= lr_s;
            end
        end
    end

    // Output stream: a word transfers on any clock where m_tvalid && m_tready; m_tvalid
    // never depends on m_tready, and the head word holds steady until it is taken.
    i2s_rx_10xe_sample_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aud_mclk     (aud_mclk),
        .aud_mrst     (aud_mrst),
        .push         (push_q),
        .push_data    ({ch, shreg}),
        .pop_req      (m_tready),
        .clr_overflow (clr_overflow),
        .head_data    (head),
        .not_empty    (m_tvalid),
        .count        (fifo_count),
        .overflow     (overflow)
    );

    assign m_tid   = head[DATA_WIDTH];
    assign m_tdata = head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_i2s_rx_10xe_deserializer.sv
// Bench for i2s_rx_10xe_deserializer: drives I2S frames at sclk = mclk/8 and
// checks popped words against a queue model of the expected FIFO contents.
module tb_i2s_rx_10xe_deserializer;
    import i2s_rx_10xe_deserializer_pkg::*;

    localparam int DW    = 24;
    localparam int SLOT  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int HALF  = 4;

    logic          aud_mclk;
    logic          aud_mrst;
    logic          enable;
    logic          sclk_in;
    logic          lrclk_in;
    logic          sdata_in;
    logic [DW-1:0] m_tdata;
    logic          m_tid;
    logic          m_tvalid;
    logic          m_tready;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          clr_overflow;
    logic          frame_err;

    int            total = 0;
    int            bad   = 0;
    logic [DW:0]   exp_q[$];
    bit            ovf_exp = 1'b0;
    int            ferr_cnt = 0;
    bit            rnd_rdy = 1'b0;
    logic          cur_lr;
    int            f0;

    i2s_rx_10xe_deserializer #(
        .DATA_WIDTH  (DW),
        .SLOT_WIDTH  (SLOT),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .aud_mclk     (aud_mclk),
        .aud_mrst     (aud_mrst),
        .enable       (enable),
        .sclk_in      (sclk_in),
        .lrclk_in     (lrclk_in),
        .sdata_in     (sdata_in),
        .m_tdata      (m_tdata),
        .m_tid        (m_tid),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .frame_err    (frame_err)
    );

    // clock / reset
    initial aud_mclk = 1'b0;
    always #5 aud_mclk = ~aud_mclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: FIFO holds at most DEPTH words unless a pop lands in the same cycle as the push.
    function automatic void model_push(input logic lr, input logic [DW-1:0] w, input bit coinc_pop);
        if (exp_q.size() < DEPTH || coinc_pop) exp_q.push_back({lr, w});
        else ovf_exp = 1'b1;
    endfunction

    // scoreboard: every handshake must match the oldest expected word
    initial begin
        forever begin
            @(negedge aud_mclk);
            #2;
            if (!aud_mrst) begin
                if (frame_err) ferr_cnt++;
                if (m_tvalid && m_tready) begin
                    check_eq("pop_model_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        check_eq("pop_word", 32'({m_tid, m_tdata}), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge aud_mclk);
            if (rnd_rdy) m_tready = 1'($urandom_range(0, 1));
        end
    end

    // drivers
    task automatic send_period(input logic lr, input logic d, input bit pulse_rdy);
        sclk_in  = 1'b0;
        lrclk_in = lr;
        sdata_in = d;
        repeat (HALF) @(negedge aud_mclk);
        sclk_in = 1'b1;
        repeat (HALF - 1) @(negedge aud_mclk);
        if (pulse_rdy) m_tready = 1'b1;
        @(negedge aud_mclk);
        if (pulse_rdy) m_tready = 1'b0;
    endtask

    // Period 0 of a slot carries the previous word's LSB; periods 1..DW carry MSB..LSB.
    task automatic send_slot(input logic lr, input logic [DW-1:0] w, input int nper,
                             input bit expect_word, input bit pulse_lsb,
                             input int en_at, input int dis_at);
        for (int i = 0; i < nper; i++) begin
            logic d;
            if (i == en_at) enable = 1'b1;
            if (i == dis_at) enable = 1'b0;
            d = (i >= 1 && i <= DW) ? w[DW - i] : 1'($urandom_range(0, 1));
            if (i == DW && expect_word) model_push(lr, w, pulse_lsb);
            send_period(lr, d, pulse_lsb && (i == DW));
        end
    endtask

    task automatic full_slot(input logic [DW-1:0] w, input bit expect_word, input bit pulse_lsb);
        send_slot(cur_lr, w, SLOT, expect_word, pulse_lsb, -1, -1);
        cur_lr = ~cur_lr;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge aud_mclk);
            n++;
        end
        repeat (4) @(negedge aud_mclk);
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        aud_mrst     = 1'b1;
        enable       = 1'b0;
        sclk_in      = 1'b0;
        lrclk_in     = 1'b0;
        sdata_in     = 1'b0;
        m_tready     = 1'b1;
        clr_overflow = 1'b0;
        cur_lr       = CH_RIGHT;
        repeat (3) @(negedge aud_mclk);
        check_eq("rst_tvalid", 32'(m_tvalid), 32'd0);
        check_eq("rst_tdata", 32'(m_tdata), 32'd0);
        check_eq("rst_tid", 32'(m_tid), 32'd0);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_frame_err", 32'(frame_err), 32'd0);
        aud_mrst = 1'b0;
        @(negedge aud_mclk);

        // enable arrives mid-slot: that slot is discarded, then fixed L/R words
        send_slot(CH_RIGHT, 24'($urandom), SLOT, 1'b0, 1'b0, 10, -1);
        cur_lr = CH_LEFT;
        full_slot(24'hA5_5A_C3, 1'b1, 1'b0);
        full_slot(24'h0F_F0_1E, 1'b1, 1'b0);
        wait_drain("fixed_lr_drain");

        // random words with a randomly stalling consumer
        rnd_rdy = 1'b1;
        for (int k = 0; k < 8; k++) full_slot(24'($urandom), 1'b1, 1'b0);
        rnd_rdy = 1'b0;
        @(negedge aud_mclk);
        m_tready = 1'b1;
        wait_drain("random_drain");
        check_eq("no_frame_err_yet", 32'(ferr_cnt), 32'd0);

        // overflow: six words into a stalled four-deep FIFO
        m_tready = 1'b0;
        ovf_exp  = 1'b0;
        for (int k = 0; k < 6; k++) full_slot(24'($urandom), 1'b1, 1'b0);
        repeat (10) @(negedge aud_mclk);
        check_eq("ovf_count", 32'(fifo_count), 32'(exp_q.size()));
        check_eq("ovf_flag", 32'(overflow), 32'(ovf_exp));
        check_eq("ovf_head", 32'({m_tid, m_tdata}), 32'(exp_q[0]));
        clr_overflow = 1'b1;
        @(negedge aud_mclk);
        clr_overflow = 1'b0;
        ovf_exp = 1'b0;
        @(negedge aud_mclk);
        check_eq("ovf_cleared", 32'(overflow), 32'(ovf_exp));

        // full FIFO, pop lands on the push cycle
        full_slot(24'($urandom), 1'b1, 1'b1);
        repeat (10) @(negedge aud_mclk);
        check_eq("full_pushpop_count", 32'(fifo_count), 32'(exp_q.size()));
        check_eq("full_pushpop_ovf", 32'(overflow), 32'(ovf_exp));
        m_tready = 1'b1;
        wait_drain("full_pushpop_drain");
        check_eq("full_pushpop_empty", 32'(fifo_count), 32'd0);

        // lrclk toggles after 10 data bits
        f0 = ferr_cnt;
        send_slot(cur_lr, 24'($urandom), 11, 1'b0, 1'b0, -1, -1);
        cur_lr = ~cur_lr;
        full_slot(24'($urandom), 1'b1, 1'b0);
        full_slot(24'($urandom), 1'b1, 1'b0);
        wait_drain("frame_err_drain");
        check_eq("frame_err_cycles", 32'(ferr_cnt - f0), 32'd1);

        // enable dropped mid-word: partial word lost, queued words kept
        m_tready = 1'b0;
        full_slot(24'($urandom), 1'b1, 1'b0);
        full_slot(24'($urandom), 1'b1, 1'b0);
        send_slot(cur_lr, 24'($urandom), SLOT, 1'b0, 1'b0, -1, 10);
        cur_lr = ~cur_lr;
        repeat (4) @(negedge aud_mclk);
        check_eq("disable_count", 32'(fifo_count), 32'(exp_q.size()));
        check_eq("disable_tvalid", 32'(m_tvalid), 32'd1);
        check_eq("disable_head", 32'({m_tid, m_tdata}), 32'(exp_q[0]));
        m_tready = 1'b1;
        wait_drain("disable_drain");
        check_eq("disable_empty", 32'(fifo_count), 32'd0);

        // reset mid-word with a word queued
        m_tready = 1'b0;
        enable   = 1'b1;
        repeat (2) @(negedge aud_mclk);
        full_slot(24'($urandom) | 24'h1, 1'b1, 1'b0);
        send_slot(cur_lr, 24'($urandom), 10, 1'b0, 1'b0, -1, -1);
        check_eq("pre_rst_count", 32'(fifo_count), 32'(exp_q.size()));
        aud_mrst = 1'b1;
        #1;
        check_eq("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
        check_eq("mid_rst_tdata", 32'(m_tdata), 32'd0);
        check_eq("mid_rst_tid", 32'(m_tid), 32'd0);
        check_eq("mid_rst_count", 32'(fifo_count), 32'd0);
        check_eq("mid_rst_overflow", 32'(overflow), 32'd0);
        check_eq("mid_rst_frame_err", 32'(frame_err), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge aud_mclk);
        aud_mrst = 1'b0;
        enable   = 1'b0;
        repeat (3) @(negedge aud_mclk);
        check_eq("post_rst_tvalid", 32'(m_tvalid), 32'd0);
        check_eq("frame_err_total", 32'(ferr_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
